// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_check_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        WT_ID,
        RD_TS,
        WT_TS,
        CMP,
        DONE
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;
    localparam int   LAT_W         = 2;

endpackage

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only link between the boot checker and the system-ID slave.
interface sysid_boot_checker_if;

    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata
    );

endinterface

// File: rtl/sysid_rd_port.sv
// Single-word Avalon-MM read port: one-cycle strobe, fixed read latency,
// rd_valid pulses in the cycle the slave data is valid.
module sysid_rd_port
    import sysid_check_pkg::*;
#(
    parameter int READ_LATENCY = 0
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        req,
    input  logic                        req_addr,
    output logic                        rd_valid,
    output logic [31:0]                 rd_data,
    sysid_boot_checker_if.master        avm
);

    localparam logic [LAT_W-1:0] LAT_LOAD =
        (READ_LATENCY > 0) ? LAT_W'(READ_LATENCY - 1) : '0;

    logic [LAT_W-1:0] lat_cnt;
    logic             waiting;

    // NOTE: registers are updated with <= so every one samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            avm.avm_read    <= 1'b0;
            avm.avm_address <= SYSID_ADDR_ID;
            lat_cnt         <= '0;
            waiting         <= 1'b0;
        end else begin
            avm.avm_read <= req;
            if (req) begin
                avm.avm_address <= req_addr;
            end
            if (avm.avm_read && READ_LATENCY > 0) begin
                lat_cnt <= LAT_LOAD;
                waiting <= 1'b1;
            end else if (waiting) begin
                if (lat_cnt == '0) begin
                    waiting <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                end
            end
        end
    end

    // Zero latency: the slave answers during the strobe cycle itself.
    assign rd_valid = (READ_LATENCY == 0) ? avm.avm_read : (waiting && lat_cnt == '0);
    assign rd_data  = avm.avm_readdata;

endmodule

// File: rtl/sysid_boot_checker.sv
// Reads the system-ID and timestamp words after reset or on request, compares
// them with build-time values, retries on mismatch and reports sys_ok/sys_err.
module sysid_boot_checker
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID  = 32'd0,
    parameter logic [31:0] EXPECTED_TS  = 32'd1495528982,
    parameter bit          CHECK_TS     = 1'b1,
    parameter int          READ_LATENCY = 0,
    parameter int          MAX_RETRY    = 2,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    sysid_boot_checker_if.master avm,
    output logic                 busy,
    output logic                 done,
    output logic                 sys_ok,
    output logic                 sys_err,
    output logic [31:0]          id_value,
    output logic [31:0]          ts_value,
    output logic [2:0]           retry_cnt
);

    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    state_t      state;
    logic        auto_pending;
    logic        launch;
    logic        cmp_pass;
    logic        can_retry;
    logic        rd_req;
    logic        rd_addr;
    logic        rd_valid;
    logic [31:0] rd_data;

    sysid_rd_port #(
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_port (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (rd_req),
        .req_addr(rd_addr),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .avm     (avm)
    );

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        cmp_pass  = (id_value == EXPECTED_ID) && (!CHECK_TS || ts_value == EXPECTED_TS);
        can_retry = retry_cnt < RETRY_LIMIT;
        launch    = 1'b0;
        rd_req    = 1'b0;
        rd_addr   = SYSID_ADDR_ID;
        case (state)
            IDLE:         launch = start || (AUTO_START && auto_pending);
            DONE:         launch = start;
            CMP:          launch = !cmp_pass && can_retry;
            RD_ID, WT_ID: begin
                rd_req  = rd_valid;
                rd_addr = SYSID_ADDR_TS;
            end
            default:      ;
        endcase
        // A new pass always begins with the ID word.
        if (launch) begin
            rd_req  = 1'b1;
            rd_addr = SYSID_ADDR_ID;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            auto_pending <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            sys_ok       <= 1'b0;
            sys_err      <= 1'b0;
            id_value     <= '0;
            ts_value     <= '0;
            retry_cnt    <= '0;
        end else begin
            auto_pending <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state <= RD_ID;
                        busy  <= 1'b1;
                    end
                end
                RD_ID, WT_ID: begin
                    if (rd_valid) begin
                        id_value <= rd_data;
                        state    <= RD_TS;
                    end else begin
                        state <= WT_ID;
                    end
                end
                RD_TS, WT_TS: begin
                    if (rd_valid) begin
                        ts_value <= rd_data;
                        state    <= CMP;
                    end else begin
                        state <= WT_TS;
                    end
                end
                CMP: begin
                    if (cmp_pass) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        sys_ok <= 1'b1;
                    end else if (can_retry) begin
                        retry_cnt <= retry_cnt + 3'd1;
                        state     <= RD_ID;
                    end else begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        sys_err <= 1'b1;
                    end
                end
                DONE: begin
                    if (launch) begin
                        state     <= RD_ID;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        sys_ok    <= 1'b0;
                        sys_err   <= 1'b0;
                        retry_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Randomized self-checking bench: three checker configurations, each against a
// latency-accurate system-ID slave model and a pass/retry outcome model.
module tb_sysid_boot_checker;

    localparam int          N       = 3;
    localparam logic [31:0] GARBAGE = 32'hBAD0_BAD0;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n   [N];
    logic        start     [N];
    logic        busy      [N];
    logic        done      [N];
    logic        sys_ok    [N];
    logic        sys_err   [N];
    logic [31:0] id_value  [N];
    logic [31:0] ts_value  [N];
    logic [2:0]  retry_cnt [N];
    logic        rd        [N];
    logic        addr      [N];
    logic [31:0] rdata     [N];
    logic [31:0] id_word   [N];
    logic [31:0] ts_word   [N];
    logic [3:0]  pv        [N] = '{default: '0};
    logic [3:0]  pa        [N] = '{default: '0};
    int          strobes   [N] = '{default: 0};
    int          addr_bad  [N] = '{default: 0};

    int checks   = 0;
    int failures = 0;

    // Configuration of each instance, mirrored from the parameter overrides below.
    function automatic int rl_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 1;
    endfunction
    function automatic int maxr_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 3 : 0;
    endfunction
    function automatic bit chk_of(input int k);
        return (k != 1);
    endfunction
    function automatic logic [31:0] eid_of(input int k);
        return (k == 0) ? 32'd0 : (k == 1) ? 32'h1234_5678 : 32'hCAFE_0002;
    endfunction
    function automatic logic [31:0] ets_of(input int k);
        return (k == 0) ? 32'd1495528982 : (k == 1) ? 32'h5A5A_0001 : 32'h0000_0777;
    endfunction

    sysid_boot_checker_if bus0 ();
    sysid_boot_checker_if bus1 ();
    sysid_boot_checker_if bus2 ();

    assign bus0.avm_readdata = rdata[0];
    assign bus1.avm_readdata = rdata[1];
    assign bus2.avm_readdata = rdata[2];
    assign rd[0]   = bus0.avm_read;
    assign rd[1]   = bus1.avm_read;
    assign rd[2]   = bus2.avm_read;
    assign addr[0] = bus0.avm_address;
    assign addr[1] = bus1.avm_address;
    assign addr[2] = bus2.avm_address;

    sysid_boot_checker dut0 (
        .clock(clock), .reset_n(reset_n[0]), .start(start[0]), .avm(bus0),
        .busy(busy[0]), .done(done[0]), .sys_ok(sys_ok[0]), .sys_err(sys_err[0]),
        .id_value(id_value[0]), .ts_value(ts_value[0]), .retry_cnt(retry_cnt[0])
    );

    sysid_boot_checker #(
        .EXPECTED_ID(32'h1234_5678), .EXPECTED_TS(32'h5A5A_0001), .CHECK_TS(1'b0),
        .READ_LATENCY(2), .MAX_RETRY(3), .AUTO_START(1'b0)
    ) dut1 (
        .clock(clock), .reset_n(reset_n[1]), .start(start[1]), .avm(bus1),
        .busy(busy[1]), .done(done[1]), .sys_ok(sys_ok[1]), .sys_err(sys_err[1]),
        .id_value(id_value[1]), .ts_value(ts_value[1]), .retry_cnt(retry_cnt[1])
    );

    sysid_boot_checker #(
        .EXPECTED_ID(32'hCAFE_0002), .EXPECTED_TS(32'h0000_0777), .CHECK_TS(1'b1),
        .READ_LATENCY(1), .MAX_RETRY(0), .AUTO_START(1'b1)
    ) dut2 (
        .clock(clock), .reset_n(reset_n[2]), .start(start[2]), .avm(bus2),
        .busy(busy[2]), .done(done[2]), .sys_ok(sys_ok[2]), .sys_err(sys_err[2]),
        .id_value(id_value[2]), .ts_value(ts_value[2]), .retry_cnt(retry_cnt[2])
    );

    // Slave model: data is valid only READ_LATENCY cycles after the strobe.
    always @(posedge clock) begin
        for (int k = 0; k < N; k++) begin
            pv[k] <= {pv[k][2:0], rd[k] === 1'b1};
            pa[k] <= {pa[k][2:0], addr[k] === 1'b1};
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            rdata[k] = GARBAGE;
            if (rl_of(k) == 0) begin
                if (rd[k] === 1'b1) rdata[k] = (addr[k] === 1'b1) ? ts_word[k] : id_word[k];
            end else if (pv[k][rl_of(k) - 1]) begin
                rdata[k] = pa[k][rl_of(k) - 1] ? ts_word[k] : id_word[k];
            end
        end
    end

    // Strobe monitor: counts read cycles and expects addresses 0,1,0,1,...
    always @(negedge clock) begin
        for (int k = 0; k < N; k++) begin
            if (rd[k] === 1'b1) begin
                if (addr[k] !== strobes[k][0]) addr_bad[k]++;
                strobes[k]++;
            end
        end
    end

    task automatic check(input string tag, input int k, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=0x%0h exp=0x%0h", tag, k, got, exp);
        end
    endtask

    function automatic logic [31:0] flags(input int k);
        return {23'b0, busy[k], done[k], sys_ok[k], sys_err[k], rd[k], addr[k], retry_cnt[k]};
    endfunction

    task automatic check_cleared(input string tag, input int k);
        check({tag, "_flags"}, k, flags(k), 32'h0);
        check({tag, "_id"},    k, id_value[k], 32'h0);
        check({tag, "_ts"},    k, ts_value[k], 32'h0);
    endtask

    // One complete check, launched by start or by reset release (auto start).
    task automatic run_check(input int k, input logic [31:0] id, input logic [31:0] ts,
                             input bit by_reset, input int poke_at);
        bit pass;
        int passes;
        int edges;
        int s0;
        id_word[k] = id;
        ts_word[k] = ts;
        pass   = (id == eid_of(k)) && (!chk_of(k) || ts == ets_of(k));
        passes = pass ? 1 : maxr_of(k) + 1;
        @(negedge clock);
        s0 = strobes[k];
        if (by_reset) reset_n[k] = 1'b1;
        else          start[k]   = 1'b1;
        @(posedge clock);
        edges = 1;
        @(negedge clock);
        start[k] = 1'b0;
        check("launch", k, flags(k), {23'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b0});
        while (done[k] !== 1'b1 && edges < 200) begin
            if (edges == poke_at) start[k] = 1'b1;
            @(posedge clock);
            edges++;
            @(negedge clock);
            start[k] = 1'b0;
        end
        check("latency",   k, edges, passes * (3 + 2 * rl_of(k)) + 1);
        check("strobes",   k, strobes[k] - s0, 2 * passes);
        check("addr_seq",  k, addr_bad[k], 0);
        check("sys_ok",    k, sys_ok[k], pass);
        check("sys_err",   k, sys_err[k], !pass);
        check("busy",      k, busy[k], 0);
        check("retry_cnt", k, retry_cnt[k], passes - 1);
        check("id_value",  k, id_value[k], id);
        check("ts_value",  k, ts_value[k], ts);
    endtask

    // Start a check, run n edges into it, then reset for one cycle.
    task automatic reset_mid(input int k, input int n, input bit strobe_now);
        @(negedge clock);
        start[k] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start[k] = 1'b0;
        repeat (n - 1) begin
            @(posedge clock);
            @(negedge clock);
        end
        check("pre_reset_read", k, rd[k], strobe_now);
        check("pre_reset_busy", k, busy[k], 1);
        reset_n[k] = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_cleared("mid_reset", k);
    endtask

    initial begin
        int s1;
        for (int k = 0; k < N; k++) begin
            reset_n[k] = 1'b0;
            start[k]   = 1'b0;
            id_word[k] = eid_of(k);
            ts_word[k] = ets_of(k);
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < N; k++) check_cleared("reset", k);

        // Auto start on reset release with matching words.
        run_check(0, 32'd0, 32'd1495528982, 1'b1, 0);
        run_check(2, 32'hCAFE_0002, 32'h0000_0777, 1'b1, 0);

        // No auto start on instance 1: it must stay idle after release.
        @(negedge clock);
        s1 = strobes[1];
        reset_n[1] = 1'b1;
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("no_auto_flags", 1, flags(1), 32'h0);
        check("no_auto_strobes", 1, strobes[1] - s1, 0);

        // Directed outcomes: bad ID with retries, bad timestamp, ignored timestamp.
        run_check(0, 32'h1, 32'd1495528982, 1'b0, 0);
        run_check(0, 32'd0, 32'hDEADBEEF, 1'b0, 0);
        run_check(1, 32'h1234_5678, 32'hDEADBEEF, 1'b0, 0);
        run_check(2, 32'hCAFE_0002, 32'hDEADBEEF, 1'b0, 0);

        // start while busy is ignored.
        run_check(0, 32'd0, 32'd1495528982, 1'b0, 2);
        run_check(1, 32'h0, 32'h0, 1'b0, 5);

        // Reset mid-read, then the auto-started fresh check.
        reset_mid(0, 2, 1'b1);
        run_check(0, 32'd0, 32'd1495528982, 1'b1, 0);
        reset_mid(2, 4, 1'b0);
        run_check(2, 32'hCAFE_0002, 32'h0000_0777, 1'b1, 0);

        // Randomized checks across all three configurations.
        for (int i = 0; i < 24; i++) begin
            int          k;
            logic [31:0] id;
            logic [31:0] ts;
            k  = $urandom_range(0, N - 1);
            id = ($urandom_range(0, 1) == 1) ? eid_of(k) : $urandom;
            ts = ($urandom_range(0, 1) == 1) ? ets_of(k) : $urandom;
            run_check(k, id, ts, 1'b0, $urandom_range(0, 8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
